// File: rtl/bpu_table.sv
// -----------------------------------------------------------------------------
// bpu_table -- fetch-stage branch prediction table.
//
// A direct-mapped BHT/BTB (ENTRY_NUM entries, 2-bit counters, full 32-bit
// targets) plus a circular return-address stack. The table is read
// combinationally at IF_PC and the prediction is registered, so PR_* describe
// the PC presented one cycle earlier. Corrections arrive from the EXE branch
// resolver on the UPD_* port and are written on the next rising edge.
//
// Ports
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   IF_PC        fetch PC to look up
//   IF_Req       lookup request valid
//   IF_Stall     freezes the prediction registers and the RAS
//   IF_Flush     kills the prediction being captured (wins over IF_Stall)
//   UPD_Valid    resolved-branch correction valid
//   UPD_PC       PC of the resolved branch
//   UPD_Type     branch type (`BIsNone/`BIsImme/`BIsCall/`BIsRetn)
//   UPD_IsTaken  resolved direction
//   UPD_Target   resolved target
//   UPD_Count    counter value that was predicted with
//   UPD_Hit      the prediction for this branch hit in the table
//   PR_Valid     registered prediction valid
//   PR_Hit       lookup hit
//   PR_Type      branch type of the hitting entry
//   PR_Count     counter of the hitting entry
//   PR_Taken     predicted direction
//   PR_Target    predicted next fetch PC
// -----------------------------------------------------------------------------

// Branch type encodings shared with CPU_Defines.svh; these definitions only
// take effect when that header has not already been included.
`ifndef BIsNone
`define BIsNone 2'b00
`endif
`ifndef BIsImme
`define BIsImme 2'b01
`endif
`ifndef BIsCall
`define BIsCall 2'b10
`endif
`ifndef BIsRetn
`define BIsRetn 2'b11
`endif

module bpu_table #(
  parameter int ENTRY_NUM = 64,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_PC,
  input  logic        IF_Req,
  input  logic        IF_Stall,
  input  logic        IF_Flush,
  input  logic        UPD_Valid,
  input  logic [31:0] UPD_PC,
  input  logic [1:0]  UPD_Type,
  input  logic        UPD_IsTaken,
  input  logic [31:0] UPD_Target,
  input  logic [1:0]  UPD_Count,
  input  logic        UPD_Hit,
  output logic        PR_Valid,
  output logic        PR_Hit,
  output logic [1:0]  PR_Type,
  output logic [1:0]  PR_Count,
  output logic        PR_Taken,
  output logic [31:0] PR_Target
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int TAG_W = 30 - IDX_W;
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic [ENTRY_NUM-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q    [ENTRY_NUM];
  logic [1:0]           type_q   [ENTRY_NUM];
  logic [1:0]           count_q  [ENTRY_NUM];
  logic [31:0]          target_q [ENTRY_NUM];

  // Return address stack: ras_ptr_q is the next slot to write, the top of
  // stack is the slot just below it (with wrap).
  logic [31:0]          ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]     ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]     ras_cnt_q, ras_cnt_d;
  logic [PTR_W-1:0]     ras_top;
  logic                 ras_empty;
  logic                 ras_push, ras_pop;

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [1:0]       lk_type;
  logic [1:0]       lk_count;
  logic [31:0]      lk_target;
  logic [31:0]      lk_pc8;
  logic             capture;

  logic             pr_hit_d, pr_taken_d;
  logic [1:0]       pr_type_d, pr_count_d;
  logic [31:0]      pr_target_d;

  assign lk_idx    = IF_PC[IDX_W+1:2];
  assign lk_tag    = IF_PC[31:IDX_W+2];
  assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_type   = type_q[lk_idx];
  assign lk_count  = count_q[lk_idx];
  assign lk_target = target_q[lk_idx];
  assign lk_pc8    = IF_PC + 32'd8;
  assign capture   = IF_Req && !IF_Stall && !IF_Flush;

  assign ras_top   = (ras_ptr_q == '0) ? PTR_LAST : ras_ptr_q - PTR_W'(1);
  assign ras_empty = (ras_cnt_q == '0);

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    pr_hit_d    = 1'b0;
    pr_type_d   = `BIsNone;
    pr_count_d  = 2'b00;
    pr_taken_d  = 1'b0;
    pr_target_d = lk_pc8;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    if (lk_hit) begin
      pr_hit_d   = 1'b1;
      pr_type_d  = lk_type;
      pr_count_d = lk_count;
      case (lk_type)
        `BIsImme: begin
          pr_taken_d  = lk_count[1];
          pr_target_d = lk_count[1] ? lk_target : lk_pc8;
        end
        `BIsCall: begin
          pr_taken_d  = 1'b1;
          pr_target_d = lk_target;
          ras_push    = capture;
        end
        `BIsRetn: begin
          if (!ras_empty) begin
            pr_taken_d  = 1'b1;
            pr_target_d = ras_mem_q[ras_top];
            ras_pop     = capture;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Prediction registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PR_Valid  <= 1'b0;
      PR_Hit    <= 1'b0;
      PR_Type   <= 2'b00;
      PR_Count  <= 2'b00;
      PR_Taken  <= 1'b0;
      PR_Target <= 32'd0;
    end else if (IF_Flush) begin
      PR_Valid  <= 1'b0;
    end else if (!IF_Stall) begin
      if (IF_Req) begin
        PR_Valid  <= 1'b1;
        PR_Hit    <= pr_hit_d;
        PR_Type   <= pr_type_d;
        PR_Count  <= pr_count_d;
        PR_Taken  <= pr_taken_d;
        PR_Target <= pr_target_d;
      end else begin
        PR_Valid  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Return address stack
  // ---------------------------------------------------------------------------
  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (ras_push) begin
      ras_ptr_d = (ras_ptr_q == PTR_LAST) ? '0 : ras_ptr_q + PTR_W'(1);
      ras_cnt_d = (ras_cnt_q == CNT_FULL) ? ras_cnt_q : ras_cnt_q + CNT_W'(1);
    end else if (ras_pop) begin
      ras_ptr_d = ras_top;
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  // NOTE: storage arrays are deliberately not reset; the valid bits and the
  // RAS occupancy gate every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!rst && ras_push) begin
      ras_mem_q[ras_ptr_q] <= lk_pc8;
    end
  end

  // ---------------------------------------------------------------------------
  // Update from the branch resolver
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_write;
  logic             upd_clear;
  logic [1:0]       upd_count_d;

  assign upd_idx   = UPD_PC[IDX_W+1:2];
  assign upd_tag   = UPD_PC[31:IDX_W+2];
  assign upd_write = UPD_Valid && (UPD_Type != `BIsNone);
  assign upd_clear = UPD_Valid && (UPD_Type == `BIsNone) && UPD_Hit;

  // Hits train the saturating counter; a fresh install starts weakly biased
  // towards the resolved direction.
  always_comb begin
    upd_count_d = UPD_IsTaken ? 2'b10 : 2'b01;
    if (UPD_Hit) begin
      if (UPD_IsTaken) begin
        upd_count_d = (UPD_Count == 2'b11) ? 2'b11 : UPD_Count + 2'b01;
      end else begin
        upd_count_d = (UPD_Count == 2'b00) ? 2'b00 : UPD_Count - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_write) begin
      valid_q[upd_idx] <= 1'b1;
    end else if (upd_clear) begin
      valid_q[upd_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && upd_write) begin
      tag_q[upd_idx]    <= upd_tag;
      type_q[upd_idx]   <= UPD_Type;
      count_q[upd_idx]  <= upd_count_d;
      target_q[upd_idx] <= UPD_Target;
    end
  end

endmodule
